// File: rtl/hnm_pp_pkg.sv
// Shared geometry and helpers for the hit-not-miss map storage block.
// Latency: n/a (constants, types and pure functions only).
// Backpressure: n/a.
package hnm_pp_pkg;

    localparam int SSIDBITS         = 8;
    localparam int NROWS_HNM        = 16;
    localparam int ROWINDEXBITS_HNM = 4;
    localparam int NCOLS_HNM        = 13;
    localparam int COLINDEXBITS_HNM = 4;

    // Fill sweep controller states.
    typedef enum logic {
        FILL_IDLE = 1'b0,
        FILL_RUN  = 1'b1
    } fillState_t;

    // SSID slicing for the default geometry: SSID = {row, col}.
    function automatic logic [ROWINDEXBITS_HNM-1:0] ssidRow(input logic [SSIDBITS-1:0] ssid);
        return ssid[SSIDBITS-1 -: ROWINDEXBITS_HNM];
    endfunction

    function automatic logic [COLINDEXBITS_HNM-1:0] ssidCol(input logic [SSIDBITS-1:0] ssid);
        return ssid[COLINDEXBITS_HNM-1:0];
    endfunction

    function automatic logic [SSIDBITS-1:0] makeSsid(input logic [ROWINDEXBITS_HNM-1:0] row,
                                                     input logic [COLINDEXBITS_HNM-1:0] col);
        return {row, col};
    endfunction

endpackage

// File: rtl/hnm_ssid_decode.sv
// Splits an SSID into {row, col} and flags whether it addresses a real map bit.
// Latency: purely combinational.
// Backpressure: none.
// Ports: ssid in; row, col, valid out (valid=0 when row or col is beyond the map).
module hnm_ssid_decode #(
    parameter int SSIDBITS         = 8,
    parameter int NROWS_HNM        = 16,
    parameter int ROWINDEXBITS_HNM = 4,
    parameter int NCOLS_HNM        = 13,
    parameter int COLINDEXBITS_HNM = 4
) (
    input  logic [SSIDBITS-1:0]         ssid,
    output logic [ROWINDEXBITS_HNM-1:0] row,
    output logic [COLINDEXBITS_HNM-1:0] col,
    output logic                        valid
);

    assign row = ssid[SSIDBITS-1 -: ROWINDEXBITS_HNM];
    assign col = ssid[COLINDEXBITS_HNM-1:0];

    // Index fields are wider than needed for a 13-column map, so the column
    // check is live; the row check only matters for non-power-of-two row counts.
    assign valid = (32'(row) < NROWS_HNM) && (32'(col) < NCOLS_HNM);

endmodule

// File: rtl/hnm_pp.sv
// Hit-not-miss map: NROWS_HNM x NCOLS_HNM flop array with bit set, row overwrite, fill sweep, bit query and row dump.
// Latency: writes land at the sampling edge; read/readRow outputs update at the sampling edge (1 cycle) and hold otherwise.
// Backpressure: writeReady/readReady are low out of reset until the first edge and during a fill sweep; requests then are dropped.
// Ports: clk, reset (async active-low); write/SSID_write, writeRow/rowWrite/dataWrite, fillSequentialRows;
//        read/SSID_read -> SSID_passed/HNM_readOutput; readRow/rowRead -> rowPassed/rowReadOutput;
//        writeReady, readReady, busy status.
module hnm_pp #(
    parameter int SSIDBITS         = hnm_pp_pkg::SSIDBITS,
    parameter int NROWS_HNM        = hnm_pp_pkg::NROWS_HNM,
    parameter int ROWINDEXBITS_HNM = hnm_pp_pkg::ROWINDEXBITS_HNM,
    parameter int NCOLS_HNM        = hnm_pp_pkg::NCOLS_HNM,
    parameter int COLINDEXBITS_HNM = hnm_pp_pkg::COLINDEXBITS_HNM
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [SSIDBITS-1:0]         SSID_write,
    input  logic                        write,
    input  logic                        writeRow,
    input  logic [ROWINDEXBITS_HNM-1:0] rowWrite,
    input  logic [NCOLS_HNM-1:0]        dataWrite,
    input  logic                        fillSequentialRows,
    input  logic [SSIDBITS-1:0]         SSID_read,
    input  logic                        read,
    input  logic [ROWINDEXBITS_HNM-1:0] rowRead,
    input  logic                        readRow,
    output logic                        writeReady,
    output logic                        readReady,
    output logic [SSIDBITS-1:0]         SSID_passed,
    output logic                        HNM_readOutput,
    output logic [ROWINDEXBITS_HNM-1:0] rowPassed,
    output logic [NCOLS_HNM-1:0]        rowReadOutput,
    output logic                        busy
);

    import hnm_pp_pkg::*;

    logic [NCOLS_HNM-1:0] mem     [NROWS_HNM];
    logic [NCOLS_HNM-1:0] memNext [NROWS_HNM];

    fillState_t                  fillState, fillStateNext;
    logic [ROWINDEXBITS_HNM-1:0] fillCnt;
    logic [NCOLS_HNM-1:0]        fillData;
    logic                        fillStart;
    logic                        fillLast;
    logic                        readyReg;

    logic [ROWINDEXBITS_HNM-1:0] wrRow, rdRow;
    logic [COLINDEXBITS_HNM-1:0] wrCol, rdCol;
    logic                        wrValid, rdValid;
    logic                        writeAcc, writeRowAcc, readAcc, readRowAcc;

    hnm_ssid_decode #(
        .SSIDBITS        (SSIDBITS),
        .NROWS_HNM       (NROWS_HNM),
        .ROWINDEXBITS_HNM(ROWINDEXBITS_HNM),
        .NCOLS_HNM       (NCOLS_HNM),
        .COLINDEXBITS_HNM(COLINDEXBITS_HNM)
    ) u_wrDecode (
        .ssid (SSID_write),
        .row  (wrRow),
        .col  (wrCol),
        .valid(wrValid)
    );

    hnm_ssid_decode #(
        .SSIDBITS        (SSIDBITS),
        .NROWS_HNM       (NROWS_HNM),
        .ROWINDEXBITS_HNM(ROWINDEXBITS_HNM),
        .NCOLS_HNM       (NCOLS_HNM),
        .COLINDEXBITS_HNM(COLINDEXBITS_HNM)
    ) u_rdDecode (
        .ssid (SSID_read),
        .row  (rdRow),
        .col  (rdCol),
        .valid(rdValid)
    );

    // readyReg is 0 only between reset and the first edge after release.
    assign busy       = (fillState == FILL_RUN);
    assign writeReady = readyReg & ~busy;
    assign readReady  = readyReg & ~busy;

    // Out-of-range targets are dropped here so the storage update needs no further checks.
    assign writeAcc    = write    & writeReady & wrValid;
    assign writeRowAcc = writeRow & writeReady & (32'(rowWrite) < NROWS_HNM);
    assign readAcc     = read     & readReady;
    assign readRowAcc  = readRow  & readReady;

    // ---------------- fill sweep FSM ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fillState <= FILL_IDLE;
        end else begin
            fillState <= fillStateNext;
        end
    end

    always_comb begin
        fillStateNext = fillState;
        fillStart     = 1'b0;
        fillLast      = 1'b0;
        unique case (fillState)
            FILL_IDLE: begin
                if (fillSequentialRows && readyReg) begin
                    fillStart     = 1'b1;
                    fillStateNext = FILL_RUN;
                end
            end
            FILL_RUN: begin
                if (32'(fillCnt) == NROWS_HNM - 1) begin
                    fillLast      = 1'b1;
                    fillStateNext = FILL_IDLE;
                end
            end
            default: fillStateNext = FILL_IDLE;
        endcase
    end

    // Fill data is captured at the pulse so dataWrite is free during the sweep.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fillCnt  <= '0;
            fillData <= '0;
            readyReg <= 1'b0;
        end else begin
            readyReg <= 1'b1;
            if (fillStart) begin
                fillCnt  <= '0;
                fillData <= dataWrite;
            end else if (busy && !fillLast) begin
                fillCnt <= fillCnt + 1'b1;
            end
        end
    end

    // ---------------- storage update ----------------
    // Row overwrite is applied before the bit set so a same-cycle write to the
    // same row lands on top of dataWrite.
    always_comb begin
        memNext = mem;
        if (busy) begin
            memNext[fillCnt] = fillData;
        end else begin
            if (writeRowAcc) begin
                memNext[rowWrite] = dataWrite;
            end
            if (writeAcc) begin
                memNext[wrRow][wrCol] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < NROWS_HNM; r++) begin
                mem[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NROWS_HNM; r++) begin
                mem[r] <= memNext[r];
            end
        end
    end

    // ---------------- read path ----------------
    // Reads use the registered array, so a same-cycle write is not visible yet.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            SSID_passed    <= '0;
            HNM_readOutput <= 1'b0;
            rowPassed      <= '0;
            rowReadOutput  <= '0;
        end else begin
            if (readAcc) begin
                SSID_passed    <= SSID_read;
                HNM_readOutput <= rdValid ? mem[rdRow][rdCol] : 1'b0;
            end
            if (readRowAcc) begin
                rowPassed     <= rowRead;
                rowReadOutput <= (32'(rowRead) < NROWS_HNM) ? mem[rowRead] : '0;
            end
        end
    end

endmodule

// File: tb/tb_hnm_pp.sv
module tb_hnm_pp;
    import hnm_pp_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  SSID_write;
    logic        write;
    logic        writeRow;
    logic [3:0]  rowWrite;
    logic [12:0] dataWrite;
    logic        fillSequentialRows;
    logic [7:0]  SSID_read;
    logic        read;
    logic [3:0]  rowRead;
    logic        readRow;
    logic        writeReady;
    logic        readReady;
    logic [7:0]  SSID_passed;
    logic        HNM_readOutput;
    logic [3:0]  rowPassed;
    logic [12:0] rowReadOutput;
    logic        busy;

    int checks = 0;
    int fails  = 0;

    // Reference map: one 13-bit word per row.
    logic [12:0] model [16];

    hnm_pp dut (
        .clk(clk), .reset(reset),
        .SSID_write(SSID_write), .write(write),
        .writeRow(writeRow), .rowWrite(rowWrite), .dataWrite(dataWrite),
        .fillSequentialRows(fillSequentialRows),
        .SSID_read(SSID_read), .read(read),
        .rowRead(rowRead), .readRow(readRow),
        .writeReady(writeReady), .readReady(readReady),
        .SSID_passed(SSID_passed), .HNM_readOutput(HNM_readOutput),
        .rowPassed(rowPassed), .rowReadOutput(rowReadOutput),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        write = 0; writeRow = 0; read = 0; readRow = 0; fillSequentialRows = 0;
        SSID_write = 0; SSID_read = 0; rowWrite = 0; rowRead = 0; dataWrite = 0;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        idle_inputs();
        tick(); tick();
        checks++;
        if ({writeReady, readReady, busy, HNM_readOutput} !== 4'b0 || SSID_passed !== 8'h0 ||
            rowPassed !== 4'h0 || rowReadOutput !== 13'h0) begin
            fails++;
            $display("FAIL reset_outputs: wr=%b rd=%b busy=%b bit=%b ssid=%h row=%h dat=%h, required all 0",
                     writeReady, readReady, busy, HNM_readOutput, SSID_passed, rowPassed, rowReadOutput);
        end
        reset = 1'b1;
        #2;
        checks++;
        if ({writeReady, readReady} !== 2'b00) begin
            fails++;
            $display("FAIL ready_before_edge: got %b%b, required 00", writeReady, readReady);
        end
        tick();
        checks++;
        if ({writeReady, readReady} !== 2'b11) begin
            fails++;
            $display("FAIL ready_after_edge: got %b%b, required 11", writeReady, readReady);
        end
        for (int r = 0; r < 16; r++) model[r] = '0;
        for (int r = 0; r < 16; r++) begin
            readRow = 1; rowRead = 4'(r);
            tick();
            checks++;
            if (rowPassed !== 4'(r) || rowReadOutput !== 13'h0) begin
                fails++;
                $display("FAIL reset_dump: row %0d got idx=%0d dat=%h, required idx=%0d dat=0", r, rowPassed, rowReadOutput, r);
            end
        end
        idle_inputs();
    endtask

    task automatic test_ssid_writes;
        logic [7:0]  list [23];
        logic [12:0] req  [16];
        list = '{8'h46, 8'h48, 8'h41, 8'h42, 8'h47, 8'h44, 8'h44, 8'h4C,
                 8'h18, 8'h36, 8'h35, 8'hC7, 8'h41, 8'h97, 8'h2B,
                 8'h8B, 8'h85, 8'h88, 8'h88, 8'h88, 8'h87, 8'h83, 8'h80};
        for (int r = 0; r < 16; r++) req[r] = '0;
        req[1] = 13'h100; req[2] = 13'h800; req[3] = 13'h060; req[4] = 13'h11D6;
        req[8] = 13'h9A9; req[9] = 13'h080; req[12] = 13'h080;
        for (int i = 0; i < 23; i++) begin
            write = 1; SSID_write = list[i];
            tick();
        end
        idle_inputs();
        for (int r = 0; r < 16; r++) begin
            readRow = 1; rowRead = 4'(r);
            tick();
            checks++;
            if (rowReadOutput !== req[r]) begin
                fails++;
                $display("FAIL ssid_write_row: row %0d got %h, required %h", r, rowReadOutput, req[r]);
            end
            model[r] = req[r];
        end
        idle_inputs();
    endtask

    task automatic test_write_row_read;
        writeRow = 1; rowWrite = 4'd5; dataWrite = 13'h0055;
        tick();
        idle_inputs();
        model[5] = 13'h0055;
        read = 1; SSID_read = makeSsid(4'd5, 4'd0);
        tick();
        checks++;
        if (HNM_readOutput !== 1'b1 || SSID_passed !== 8'h50) begin
            fails++;
            $display("FAIL read_5_0: got bit=%b ssid=%h, required bit=1 ssid=50", HNM_readOutput, SSID_passed);
        end
        SSID_read = makeSsid(4'd5, 4'd1);
        tick();
        checks++;
        if (HNM_readOutput !== 1'b0 || SSID_passed !== 8'h51) begin
            fails++;
            $display("FAIL read_5_1: got bit=%b ssid=%h, required bit=0 ssid=51", HNM_readOutput, SSID_passed);
        end
        read = 0;
        tick();
        checks++;
        if (HNM_readOutput !== 1'b0 || SSID_passed !== 8'h51) begin
            fails++;
            $display("FAIL read_hold: got bit=%b ssid=%h, required bit=0 ssid=51", HNM_readOutput, SSID_passed);
        end
        // Same-cycle overwrite and bit set on one row, plus an out-of-range column set.
        writeRow = 1; rowWrite = 4'd6; dataWrite = 13'h0F00;
        write = 1; SSID_write = makeSsid(4'd6, 4'd1);
        tick();
        write = 1; writeRow = 0; SSID_write = makeSsid(4'd6, 4'd14);
        tick();
        idle_inputs();
        model[6] = 13'h0F02;
        readRow = 1; rowRead = 4'd6; read = 1; SSID_read = makeSsid(4'd6, 4'd14);
        tick();
        checks++;
        if (rowReadOutput !== 13'h0F02 || HNM_readOutput !== 1'b0) begin
            fails++;
            $display("FAIL row_and_bit_same_cycle: got row=%h bit=%b, required row=0F02 bit=0", rowReadOutput, HNM_readOutput);
        end
        idle_inputs();
    endtask

    task automatic test_fill;
        logic [7:0] heldSsid;
        logic [3:0] heldRow;
        heldSsid = SSID_passed;
        heldRow  = rowPassed;
        fillSequentialRows = 1; dataWrite = 13'h1ABC;
        tick();
        idle_inputs();
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (busy !== 1'b1 || writeReady !== 1'b0 || readReady !== 1'b0) begin
                fails++;
                $display("FAIL fill_busy: cycle %0d got busy=%b wr=%b rd=%b, required 1 0 0", i, busy, writeReady, readReady);
            end
            checks++;
            if (SSID_passed !== heldSsid || rowPassed !== heldRow) begin
                fails++;
                $display("FAIL fill_read_ignored: cycle %0d got ssid=%h row=%h, required %h %h", i, SSID_passed, rowPassed, heldSsid, heldRow);
            end
            write = 1; SSID_write = 8'($urandom_range(0, 255));
            writeRow = 1; rowWrite = 4'($urandom_range(0, 15)); dataWrite = 13'($urandom);
            read = 1; SSID_read = 8'($urandom_range(0, 255));
            readRow = 1; rowRead = 4'($urandom_range(0, 15));
            fillSequentialRows = 1'($urandom_range(0, 1));
            tick();
        end
        idle_inputs();
        checks++;
        if (busy !== 1'b0 || writeReady !== 1'b1 || readReady !== 1'b1) begin
            fails++;
            $display("FAIL fill_end: got busy=%b wr=%b rd=%b, required 0 1 1", busy, writeReady, readReady);
        end
        for (int r = 0; r < 16; r++) begin
            model[r] = 13'h1ABC;
            readRow = 1; rowRead = 4'(r);
            tick();
            checks++;
            if (rowReadOutput !== 13'h1ABC) begin
                fails++;
                $display("FAIL fill_data: row %0d got %h, required 1abc", r, rowReadOutput);
            end
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid_fill;
        fillSequentialRows = 1; dataWrite = 13'($urandom);
        tick();
        idle_inputs();
        repeat (5) tick();
        reset = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || writeReady !== 1'b0 || readReady !== 1'b0) begin
            fails++;
            $display("FAIL midfill_reset: got busy=%b wr=%b rd=%b, required 0 0 0", busy, writeReady, readReady);
        end
        tick();
        reset = 1'b1;
        #1;
        checks++;
        if ({writeReady, readReady, busy} !== 3'b000) begin
            fails++;
            $display("FAIL midfill_release: got wr=%b rd=%b busy=%b, required 0 0 0", writeReady, readReady, busy);
        end
        tick();
        checks++;
        if ({writeReady, readReady, busy} !== 3'b110) begin
            fails++;
            $display("FAIL midfill_ready: got wr=%b rd=%b busy=%b, required 1 1 0", writeReady, readReady, busy);
        end
        for (int r = 0; r < 16; r++) begin
            model[r] = '0;
            readRow = 1; rowRead = 4'(r);
            tick();
            checks++;
            if (rowReadOutput !== 13'h0 || busy !== 1'b0) begin
                fails++;
                $display("FAIL midfill_clear: row %0d got %h busy=%b, required 0 busy=0", r, rowReadOutput, busy);
            end
        end
        idle_inputs();
    endtask

    task automatic test_same_cycle;
        write = 1; SSID_write = makeSsid(4'd7, 4'd3);
        readRow = 1; rowRead = 4'd7;
        tick();
        write = 0;
        checks++;
        if (rowReadOutput !== 13'h0 || rowPassed !== 4'd7) begin
            fails++;
            $display("FAIL same_cycle_pre: got %h idx=%0d, required 0 idx=7", rowReadOutput, rowPassed);
        end
        tick();
        checks++;
        if (rowReadOutput !== 13'h0008) begin
            fails++;
            $display("FAIL same_cycle_post: got %h, required 0008", rowReadOutput);
        end
        model[7] = 13'h0008;
        idle_inputs();
    endtask

    task automatic test_random;
        logic        expBit;
        logic [7:0]  expSsid;
        logic [3:0]  expIdx;
        logic [12:0] expRow;
        int wr, wc, rr, rc;
        expBit = 0; expSsid = 0; expIdx = 0; expRow = 0;
        for (int i = 0; i < 300; i++) begin
            wr = $urandom_range(0, 15); wc = $urandom_range(0, 15);
            rr = $urandom_range(0, 15); rc = $urandom_range(0, 15);
            write     = 1'($urandom_range(0, 1));
            writeRow  = ($urandom_range(0, 3) == 0);
            read      = (i == 0) || ($urandom_range(0, 1) == 1);
            readRow   = (i == 0) || ($urandom_range(0, 1) == 1);
            SSID_write = makeSsid(4'(wr), 4'(wc));
            rowWrite   = ($urandom_range(0, 1) == 1) ? 4'(wr) : 4'($urandom_range(0, 15));
            dataWrite  = 13'($urandom);
            SSID_read  = makeSsid(4'(rr), 4'(rc));
            rowRead    = 4'($urandom_range(0, 15));
            // Reads see the map as it stood before this cycle's writes.
            if (read) begin
                expSsid = SSID_read;
                expBit  = (rc < 13) ? model[rr][rc] : 1'b0;
            end
            if (readRow) begin
                expIdx = rowRead;
                expRow = model[rowRead];
            end
            if (writeRow) model[rowWrite] = dataWrite;
            if (write && wc < 13) model[wr] = model[wr] | 13'(1 << wc);
            tick();
            checks++;
            if (HNM_readOutput !== expBit || SSID_passed !== expSsid) begin
                fails++;
                $display("FAIL rand_read: iter %0d got bit=%b ssid=%h, required bit=%b ssid=%h", i, HNM_readOutput, SSID_passed, expBit, expSsid);
            end
            checks++;
            if (rowReadOutput !== expRow || rowPassed !== expIdx) begin
                fails++;
                $display("FAIL rand_row: iter %0d got idx=%0d dat=%h, required idx=%0d dat=%h", i, rowPassed, rowReadOutput, expIdx, expRow);
            end
        end
        idle_inputs();
        for (int r = 0; r < 16; r++) begin
            readRow = 1; rowRead = 4'(r);
            tick();
            checks++;
            if (rowReadOutput !== model[r]) begin
                fails++;
                $display("FAIL rand_final: row %0d got %h, required %h", r, rowReadOutput, model[r]);
            end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_ssid_writes();
        test_write_row_read();
        test_fill();
        test_reset_mid_fill();
        test_same_cycle();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
